// File: rtl/gdu_pkg.sv
// Shared graphics display unit types: screen geometry, pixel types
// and the scanout FSM state encoding.
package gdu_pkg;

    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int WORDS_PER_LINE = 320;
    localparam int PIX_OPAQUE_BIT = 12;

    typedef logic [15:0] pixel_t;
    typedef pixel_t [1:0] pixel_pair_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        DRAIN,
        FLUSH
    } fbr_state_t;

endpackage

// File: rtl/fbr_fifo.sv
// Synchronous show-ahead word FIFO for the frame buffer reader.
// Head word is visible on o_rdata whenever o_empty is low.
module fbr_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_wr    = i_wr && (r_count != (AW+1)'(DEPTH));
    assign w_rd    = i_rd && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Scanout: burst-reads a frame from SDRAM, emits a 16-bit pixel stream.
// Option: FRAME_BUFFER_READER_TRANSPARENT_BLACK_EN blanks non-opaque pixels.
module frame_buffer_reader
    import gdu_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int LINE_WORDS = WORDS_PER_LINE,
    parameter int LINES      = SCREEN_H,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] frame_address,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_burstcount,
    output logic [3:0]  avm_byteenable,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol
);

    localparam int CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int TOTAL_WORDS = LINE_WORDS * LINES;
    localparam int LAST_X      = 2 * LINE_WORDS - 1;

    fbr_state_t    r_state;
    logic [31:0]   r_base;
    logic [31:0]   r_words_req;
    logic [CW-1:0] r_outstanding;
    logic          r_busy;
    logic          r_done;
    logic          r_avm_read;
    logic [31:0]   r_avm_address;
    logic [3:0]    r_avm_burstcount;
    logic [3:0]    r_avm_byteenable;

    logic          r_pix_valid;
    pixel_t        r_pix_data;
    pixel_t        r_hi;
    logic          r_is_hi;
    logic          r_sof;
    logic          r_eol;
    logic [15:0]   r_x;
    logic [15:0]   r_y;

    logic          w_fifo_wr;
    logic          w_fifo_empty;
    logic [31:0]   w_fifo_rdata;
    logic [CW-1:0] w_fifo_count;
    logic [31:0]   w_reserve;
    logic          w_start_acc;
    logic          w_fire;
    logic          w_pop;
    logic          w_last_fire;
    pixel_pair_t   w_pair;
    logic [15:0]   w_nx;
    logic [15:0]   w_ny;

    function automatic pixel_t f_pix(input pixel_t p);
`ifdef FRAME_BUFFER_READER_TRANSPARENT_BLACK_EN
        return p[PIX_OPAQUE_BIT] ? p : '0;
`else
        return p;
`endif
    endfunction

    assign w_start_acc = (r_state == IDLE) && start && !r_done;
    assign w_fifo_wr   = (r_state == DRAIN) && avm_readdatavalid
                         && (r_outstanding != '0);
    assign w_reserve   = 32'(w_fifo_count) + 32'(r_outstanding)
                         + 32'(BURST_LEN);
    assign w_fire      = r_pix_valid && pix_ready;
    assign w_pop       = !w_fifo_empty && (!r_pix_valid || (w_fire && r_is_hi));
    assign w_last_fire = w_fifo_empty && (!r_pix_valid || (w_fire && r_is_hi));
    assign w_pair      = pixel_pair_t'(w_fifo_rdata);

    fbr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (w_fifo_wr),
        .i_wdata (avm_readdata),
        .i_rd    (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_base           <= '0;
            r_words_req      <= '0;
            r_outstanding    <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_avm_read       <= 1'b0;
            r_avm_address    <= '0;
            r_avm_burstcount <= '0;
            r_avm_byteenable <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: if (w_start_acc) begin
                    r_base      <= frame_address;
                    r_words_req <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= CHECK;
                end
                CHECK: begin
                    if (r_words_req == 32'(TOTAL_WORDS)) begin
                        r_state <= FLUSH;
                    end else if (w_reserve <= 32'(FIFO_DEPTH)) begin
                        r_avm_read       <= 1'b1;
                        r_avm_address    <= r_base + (r_words_req << 2);
                        r_avm_burstcount <= 4'(BURST_LEN);
                        r_avm_byteenable <= 4'hF;
                        r_state          <= REQ;
                    end
                end
                REQ: if (!avm_waitrequest) begin
                    r_avm_read    <= 1'b0;
                    r_words_req   <= r_words_req + 32'(BURST_LEN);
                    r_outstanding <= r_outstanding + CW'(BURST_LEN);
                    r_state       <= DRAIN;
                end
                DRAIN: if (w_fifo_wr) begin
                    r_outstanding <= r_outstanding - 1'b1;
                    if (r_outstanding == CW'(1)) r_state <= CHECK;
                end
                FLUSH: if (w_last_fire) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Coordinates of the pixel that will be on the output next cycle.
    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        if (w_fire) begin
            if (r_x == 16'(LAST_X)) begin
                w_nx = '0;
                w_ny = r_y + 1'b1;
            end else begin
                w_nx = r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_hi        <= '0;
            r_is_hi     <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
        end else begin
            if (w_start_acc) begin
                r_x <= '0;
                r_y <= '0;
            end else begin
                r_x <= w_nx;
                r_y <= w_ny;
            end
            if (w_pop) begin
                r_pix_data  <= f_pix(w_pair[0]);
                r_hi        <= w_pair[1];
                r_is_hi     <= 1'b0;
                r_pix_valid <= 1'b1;
                r_sof       <= (w_nx == '0) && (w_ny == '0);
                r_eol       <= (w_nx == 16'(LAST_X));
            end else if (w_fire && !r_is_hi) begin
                r_pix_data <= f_pix(r_hi);
                r_is_hi    <= 1'b1;
                r_sof      <= (w_nx == '0) && (w_ny == '0);
                r_eol      <= (w_nx == 16'(LAST_X));
            end else if (w_fire) begin
                r_pix_valid <= 1'b0;
                r_sof       <= 1'b0;
                r_eol       <= 1'b0;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign avm_read       = r_avm_read;
    assign avm_address    = r_avm_address;
    assign avm_burstcount = r_avm_burstcount;
    assign avm_byteenable = r_avm_byteenable;
    assign pix_valid      = r_pix_valid;
    assign pix_data       = r_pix_data;
    assign pix_sof        = r_sof;
    assign pix_eol        = r_eol;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader on a 4-word x 2-line frame
// with an Avalon burst slave model returning word = byte address.
module tb_frame_buffer_reader;

    localparam int BL = 2;
    localparam int LW = 4;
    localparam int LN = 2;
    localparam int FD = 8;
    localparam int NWORDS = LW * LN;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] frame_address = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] avm_address;
    logic [3:0]  avm_burstcount;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_sof;
    logic        pix_eol;

    frame_buffer_reader #(
        .BURST_LEN  (BL),
        .LINE_WORDS (LW),
        .LINES      (LN),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_address     (frame_address),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_burstcount    (avm_burstcount),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_sof           (pix_sof),
        .pix_eol           (pix_eol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] beat_q[$];
    logic [31:0] req_log[$];
    logic [15:0] pix_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_hold = 0;
    int stall_idx = -1;
    int stall_left = 0;
    int stall_seen = 0;
    int stall_unstable = 0;
    int req_cnt = 0;
    int beats_sent = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int hs_cyc = -1;
    int first_beat_cyc = -1;
    int first_pix_cyc = -1;
    int max_fifo = 0;
    int resv_viol = 0;
    int ovf = 0;
    bit gap_mode = 0;
    bit gap_tog = 0;
    logic [31:0] stall_addr;
    logic [3:0]  stall_bc;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h2000) return 32'h1FFF_0000;
        if (a == 32'h2004) return 32'h0000_0FFF;
        return a;
    endfunction

    function automatic logic [15:0] model_pix(input logic [15:0] p);
`ifdef FRAME_BUFFER_READER_TRANSPARENT_BLACK_EN
        return p[12] ? p : 16'h0000;
`else
        return p;
`endif
    endfunction

    // Slave model, ready driver and pixel scoreboard, all at negedge.
    always @(negedge clk) begin : bfm
        exp_t e;
        cyc++;
        if (ready_hold > 0) begin
            pix_ready = 1'b0;
            ready_hold--;
        end else begin
            pix_ready = 1'b1;
        end
        if (beat_q.size() > 0 && (!gap_mode || gap_tog)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = beat_q.pop_front();
            beats_sent++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
        end
        gap_tog = !gap_tog;
        if (avm_read && req_cnt == stall_idx && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            if (stall_seen == 0) begin
                stall_addr = avm_address;
                stall_bc = avm_burstcount;
            end else if (avm_address !== stall_addr
                         || avm_burstcount !== stall_bc) begin
                stall_unstable++;
            end
            stall_seen++;
            stall_left--;
        end else begin
            avm_waitrequest = 1'b0;
        end
        if (!reset && avm_read && !avm_waitrequest) begin
            if (int'(dut.w_fifo_count) + BL > FD) resv_viol++;
            for (int i = 0; i < BL; i++)
                beat_q.push_back(mem_word(avm_address + 32'(4 * i)));
            req_log.push_back(avm_address);
            req_cnt++;
        end
        if (int'(dut.w_fifo_count) > max_fifo)
            max_fifo = int'(dut.w_fifo_count);
        if (!reset && pix_valid && first_pix_cyc < 0) first_pix_cyc = cyc;
        if (!reset && prev_stall && pix_valid) begin
            checks++;
            if ({pix_data, pix_sof, pix_eol} !== prev_out) begin
                errors++;
                $display("FAIL hold_stable got=%h required=%h",
                         {pix_data, pix_sof, pix_eol}, prev_out);
            end
        end
        if (!reset && pix_valid && pix_ready) begin
            hs_cyc = cyc;
            pix_log.push_back(pix_data);
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_extra got=%h required=none", pix_data);
            end else begin
                e = sb_q.pop_front();
                if ({pix_data, pix_sof, pix_eol} !== {e.data, e.sof, e.eol}) begin
                    errors++;
                    $display("FAIL pixel got=%h/%b/%b required=%h/%b/%b",
                             pix_data, pix_sof, pix_eol, e.data, e.sof, e.eol);
                end
            end
        end
        prev_stall = pix_valid && !pix_ready;
        prev_out = {pix_data, pix_sof, pix_eol};
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        if (!reset && dut.w_fifo_wr && int'(dut.w_fifo_count) == FD) ovf++;
    end

    task automatic push_frame(input logic [31:0] base);
        exp_t e;
        logic [31:0] w;
        int p;
        for (int i = 0; i < NWORDS; i++) begin
            w = mem_word(base + 32'(4 * i));
            for (int h = 0; h < 2; h++) begin
                p = 2 * i + h;
                e.data = model_pix(h == 0 ? w[15:0] : w[31:16]);
                e.sof = (p == 0);
                e.eol = ((p % (2 * LW)) == 2 * LW - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic clear_log();
        req_log.delete();
        pix_log.delete();
        req_cnt = 0;
        first_beat_cyc = -1;
        first_pix_cyc = -1;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({avm_read, avm_address, avm_burstcount, avm_byteenable} !== '0) begin
            errors++;
            $display("FAIL reset_avm got=%b/%h/%h/%h required=0",
                     avm_read, avm_address, avm_burstcount, avm_byteenable);
        end
        checks++;
        if ({pix_valid, pix_sof, pix_eol, busy, done, pix_data} !== '0) begin
            errors++;
            $display("FAIL reset_pix got=%b%b%b%b%b/%h required=0",
                     pix_valid, pix_sof, pix_eol, busy, done, pix_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input logic [31:0] base);
        bit ok;
        int d0;
        clear_log();
        d0 = done_cnt;
        push_frame(base);
        @(negedge clk);
        frame_address = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || avm_read !== 1'b0) begin
            errors++;
            $display("FAIL basic_check_state got=%b/%b required=1/0", busy, avm_read);
        end
        @(negedge clk);
        checks++;
        if ({avm_read, avm_address, avm_burstcount, avm_byteenable}
            !== {1'b1, base, 4'd2, 4'hF}) begin
            errors++;
            $display("FAIL basic_first_req got=%b/%h/%h/%h required=1/%h/2/f",
                     avm_read, avm_address, avm_burstcount, avm_byteenable, base);
        end
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done got=timeout required=done");
        end
        checks++;
        if (req_log.size() != 4) begin
            errors++;
            $display("FAIL basic_req_count got=%0d required=4", req_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (req_log[i] !== base + 32'(8 * i)) begin
                    errors++;
                    $display("FAIL basic_req_addr got=%h required=%h",
                             req_log[i], base + 32'(8 * i));
                end
            end
        end
        checks++;
        if (first_pix_cyc - first_beat_cyc != 2) begin
            errors++;
            $display("FAIL basic_latency got=%0d required=2",
                     first_pix_cyc - first_beat_cyc);
        end
        checks++;
        if (done_cyc != hs_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_timing got=%0d required=%0d",
                     done_cyc, hs_cyc + 1);
        end
        checks++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got=left%0d/busy%b required=0/0",
                     sb_q.size(), busy);
        end
    endtask

    task automatic test_waitrequest();
        bit ok;
        int d0;
        clear_log();
        d0 = done_cnt;
        stall_idx = 1;
        stall_left = 5;
        stall_seen = 0;
        stall_unstable = 0;
        push_frame(32'h1000);
        @(negedge clk);
        frame_address = 32'h1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || stall_seen != 5) begin
            errors++;
            $display("FAIL wait_stall got=ok%b/stall%0d required=1/5", ok, stall_seen);
        end
        checks++;
        if (stall_unstable != 0 || stall_addr !== 32'h1008 || stall_bc !== 4'd2) begin
            errors++;
            $display("FAIL wait_stable got=%0d/%h/%h required=0/1008/2",
                     stall_unstable, stall_addr, stall_bc);
        end
        checks++;
        if (req_cnt != 4) begin
            errors++;
            $display("FAIL wait_req_count got=%0d required=4", req_cnt);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL wait_left got=%0d required=0", sb_q.size());
        end
        stall_idx = -1;
    endtask

    task automatic test_ready_stall();
        bit ok;
        int d0;
        clear_log();
        d0 = done_cnt;
        max_fifo = 0;
        resv_viol = 0;
        ovf = 0;
        push_frame(32'h1000);
        @(negedge clk);
        ready_hold = 30;
        frame_address = 32'h1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || sb_q.size() != 0) begin
            errors++;
            $display("FAIL ready_done got=ok%b/left%0d required=1/0", ok, sb_q.size());
        end
        checks++;
        if (max_fifo != 7) begin
            errors++;
            $display("FAIL ready_fifo_fill got=%0d required=7", max_fifo);
        end
        checks++;
        if (resv_viol != 0 || ovf != 0) begin
            errors++;
            $display("FAIL ready_reserve got=%0d/%0d required=0/0", resv_viol, ovf);
        end
        checks++;
        if (req_cnt != 4) begin
            errors++;
            $display("FAIL ready_req_count got=%0d required=4", req_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        bit seen;
        clear_log();
        d0 = done_cnt;
        seen = 0;
        push_frame(32'h1000);
        @(negedge clk);
        frame_address = 32'h1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        frame_address = 32'h5000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        frame_address = 32'h6000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (!seen || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL start_frames got=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (req_cnt != 4 || req_log[0] !== 32'h1000) begin
            errors++;
            $display("FAIL start_reqs got=%0d required=4", req_cnt);
        end
        checks++;
        if (busy !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL start_idle got=busy%b/left%0d required=0/0",
                     busy, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        clear_log();
        beats_sent = 0;
        hit = 0;
        gap_mode = 1;
        push_frame(32'h3000);
        @(negedge clk);
        frame_address = 32'h3000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (beats_sent >= 3) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rstmid_beats got=%0d required=3", beats_sent);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        checks++;
        if ({avm_read, avm_address, avm_burstcount, avm_byteenable,
             pix_valid, pix_sof, pix_eol, busy, done, pix_data} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%b/%h/%b/%b/%h required=0",
                     avm_read, avm_address, pix_valid, busy, pix_data);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (beats_sent != 4 || int'(dut.w_fifo_count) != 0) begin
            errors++;
            $display("FAIL rstmid_late_beat got=beats%0d/fifo%0d required=4/0",
                     beats_sent, dut.w_fifo_count);
        end
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got=%b/%b required=0/0", pix_valid, busy);
        end
        gap_mode = 0;
        test_basic(32'h1000);
    endtask

    task automatic test_transparent();
        bit ok;
        int d0;
        logic [15:0] req[4];
`ifdef FRAME_BUFFER_READER_TRANSPARENT_BLACK_EN
        req = '{16'h0000, 16'h1FFF, 16'h0000, 16'h0000};
`else
        req = '{16'h0000, 16'h1FFF, 16'h0FFF, 16'h0000};
`endif
        clear_log();
        d0 = done_cnt;
        push_frame(32'h2000);
        @(negedge clk);
        frame_address = 32'h2000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || pix_log.size() != 2 * NWORDS) begin
            errors++;
            $display("FAIL transp_done got=ok%b/pix%0d required=1/16",
                     ok, pix_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pix_log[i] !== req[i]) begin
                    errors++;
                    $display("FAIL transp_pix%0d got=%h required=%h",
                             i, pix_log[i], req[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(32'h1000);
        test_waitrequest();
        test_ready_stall();
        test_start_ignored();
        test_reset_mid();
        test_transparent();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
